// File: rtl/gemm_tile_sequencer.sv
// Tiling sequencer for the gemm accelerator: walks the N/M/K tile loops of a whole-matrix
// job and programs gemm's registers over its system bus, throttling on full/done status.
module gemm_tile_sequencer #(
  parameter int unsigned SYS_ROWS  = 32'd16,
  parameter int unsigned SYS_COLS  = 32'd16,
  parameter int unsigned M_TILE    = 32'd16,
  parameter logic [31:0] GEMM_BASE = 32'h9000_0000,
  parameter int unsigned DIM_W     = 32'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      c_base,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      tile_count,
  output logic             system_bus_en,
  output logic             system_bus_rdwr,
  output logic [31:0]      system_bus_addr,
  output logic [31:0]      system_bus_wr_data,
  input  logic [31:0]      system_bus_rd_data
);

  // Loop indices get one spare bit so n/m/k never wrap when stepping past a full-range dimension.
  localparam int unsigned IW = DIM_W + 32'd1;

  localparam logic [31:0] REG_A    = GEMM_BASE + 32'd0;
  localparam logic [31:0] REG_B    = GEMM_BASE + 32'd4;
  localparam logic [31:0] REG_C    = GEMM_BASE + 32'd8;
  localparam logic [31:0] REG_AS   = GEMM_BASE + 32'd12;
  localparam logic [31:0] REG_BS   = GEMM_BASE + 32'd16;
  localparam logic [31:0] REG_CTRL = GEMM_BASE + 32'd20;
  localparam logic [31:0] REG_DIM  = GEMM_BASE + 32'd24;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CALC      = 4'd1,
    S_WR_AS     = 4'd2,
    S_WR_BS     = 4'd3,
    S_WR_A      = 4'd4,
    S_WR_B      = 4'd5,
    S_WR_C      = 4'd6,
    S_WR_CTRL   = 4'd7,
    S_WR_DIM    = 4'd8,
    S_POLL      = 4'd9,
    S_ADVANCE   = 4'd10,
    S_DONE_POLL = 4'd11
  } state_t;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t           state_r;
  logic [31:0]      a_base_r;
  logic [31:0]      b_base_r;
  logic [31:0]      c_base_r;
  logic [DIM_W-1:0] dim_m_r;
  logic [DIM_W-1:0] dim_k_r;
  logic [DIM_W-1:0] dim_n_r;
  logic [IW-1:0]    n_idx_r;
  logic [IW-1:0]    m_idx_r;
  logic [IW-1:0]    k_idx_r;
  logic [31:0]      ta_r;
  logic [31:0]      tb_r;
  logic [31:0]      tc_r;
  logic [31:0]      ctrl_r;
  logic [31:0]      dim_r;
  logic             poll_armed_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [31:0]      tile_count_r;
  logic             en_r;
  logic             rdwr_r;
  logic [31:0]      addr_r;
  logic [31:0]      wr_data_r;

  logic [31:0]      k32_s, m32_s, n32_s;
  logic [31:0]      dk32_s, dm32_s, dn32_s;
  logic [31:0]      kt_s, mt_s, nt_s;
  logic [31:0]      ta_s, tb_s, tc_s, ctrl_s, dim_word_s;
  logic             first_s, last_s;
  logic [IW-1:0]    k_next_s, m_next_s, n_next_s;
  logic             job_end_s;
  logic             zero_dim_s;

  assign busy               = busy_r;
  assign done               = done_r;
  assign err                = err_r;
  assign tile_count         = tile_count_r;
  assign system_bus_en      = en_r;
  assign system_bus_rdwr    = rdwr_r;
  assign system_bus_addr    = addr_r;
  assign system_bus_wr_data = wr_data_r;

  assign zero_dim_s = (dim_m == {DIM_W{1'b0}}) || (dim_k == {DIM_W{1'b0}}) ||
                      (dim_n == {DIM_W{1'b0}});

  // Per-tile register values for the current (n, m, k) position, all modulo 2^32.
  always_comb begin
    k32_s      = 32'(k_idx_r);
    m32_s      = 32'(m_idx_r);
    n32_s      = 32'(n_idx_r);
    dk32_s     = 32'(dim_k_r);
    dm32_s     = 32'(dim_m_r);
    dn32_s     = 32'(dim_n_r);
    kt_s       = min32(SYS_ROWS, dk32_s - k32_s);
    mt_s       = min32(M_TILE, dm32_s - m32_s);
    nt_s       = min32(SYS_COLS, dn32_s - n32_s);
    ta_s       = a_base_r + m32_s * dk32_s + k32_s;
    tb_s       = b_base_r + (k32_s + kt_s - 32'd1) * dn32_s + n32_s;
    tc_s       = c_base_r + m32_s * dn32_s + n32_s;
    first_s    = (k32_s == 32'd0);
    last_s     = ((k32_s + SYS_ROWS) >= dk32_s);
    ctrl_s     = {30'd0, first_s, last_s};
    dim_word_s = mt_s | (kt_s << 5) | (nt_s << 10);
  end

  // Next loop position: k innermost, then m, then n; job ends once n steps past N.
  always_comb begin
    k_next_s = k_idx_r;
    m_next_s = m_idx_r;
    n_next_s = n_idx_r;
    if ((k32_s + SYS_ROWS) < dk32_s) begin
      k_next_s = IW'(k32_s + SYS_ROWS);
    end else begin
      k_next_s = {IW{1'b0}};
      if ((m32_s + M_TILE) < dm32_s) begin
        m_next_s = IW'(m32_s + M_TILE);
      end else begin
        m_next_s = {IW{1'b0}};
        n_next_s = IW'(n32_s + SYS_COLS);
      end
    end
    job_end_s = (32'(n_next_s) >= dn32_s);
  end

  // Sequencer FSM; bus outputs are loaded on entry to the state that owns the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      a_base_r     <= 32'd0;
      b_base_r     <= 32'd0;
      c_base_r     <= 32'd0;
      dim_m_r      <= {DIM_W{1'b0}};
      dim_k_r      <= {DIM_W{1'b0}};
      dim_n_r      <= {DIM_W{1'b0}};
      n_idx_r      <= {IW{1'b0}};
      m_idx_r      <= {IW{1'b0}};
      k_idx_r      <= {IW{1'b0}};
      ta_r         <= 32'd0;
      tb_r         <= 32'd0;
      tc_r         <= 32'd0;
      ctrl_r       <= 32'd0;
      dim_r        <= 32'd0;
      poll_armed_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      tile_count_r <= 32'd0;
      en_r         <= 1'b0;
      rdwr_r       <= 1'b0;
      addr_r       <= 32'd0;
      wr_data_r    <= 32'd0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          en_r <= 1'b0;
          if (start) begin
            a_base_r <= a_base;
            b_base_r <= b_base;
            c_base_r <= c_base;
            dim_m_r  <= dim_m;
            dim_k_r  <= dim_k;
            dim_n_r  <= dim_n;
            if (zero_dim_s) begin
              err_r <= 1'b1;
            end else begin
              tile_count_r <= 32'd0;
              busy_r       <= 1'b1;
              n_idx_r      <= {IW{1'b0}};
              m_idx_r      <= {IW{1'b0}};
              k_idx_r      <= {IW{1'b0}};
              state_r      <= S_CALC;
            end
          end
        end
        S_CALC: begin
          ta_r      <= ta_s;
          tb_r      <= tb_s;
          tc_r      <= tc_s;
          ctrl_r    <= ctrl_s;
          dim_r     <= dim_word_s;
          en_r      <= 1'b1;
          rdwr_r    <= 1'b1;
          addr_r    <= REG_AS;
          wr_data_r <= 32'(dim_k_r);
          state_r   <= S_WR_AS;
        end
        S_WR_AS: begin
          addr_r    <= REG_BS;
          wr_data_r <= 32'(dim_n_r);
          state_r   <= S_WR_BS;
        end
        S_WR_BS: begin
          addr_r    <= REG_A;
          wr_data_r <= ta_r;
          state_r   <= S_WR_A;
        end
        S_WR_A: begin
          addr_r    <= REG_B;
          wr_data_r <= tb_r;
          state_r   <= S_WR_B;
        end
        S_WR_B: begin
          addr_r    <= REG_C;
          wr_data_r <= tc_r;
          state_r   <= S_WR_C;
        end
        S_WR_C: begin
          addr_r    <= REG_CTRL;
          wr_data_r <= ctrl_r;
          state_r   <= S_WR_CTRL;
        end
        S_WR_CTRL: begin
          addr_r       <= REG_DIM;
          wr_data_r    <= dim_r;
          tile_count_r <= tile_count_r + 32'd1;
          state_r      <= S_WR_DIM;
        end
        S_WR_DIM: begin
          rdwr_r       <= 1'b0;
          addr_r       <= REG_A;
          poll_armed_r <= 1'b0;
          state_r      <= S_POLL;
        end
        S_POLL: begin
          // The first poll cycle only issues the read; its data arrives one cycle later.
          if (!poll_armed_r) begin
            poll_armed_r <= 1'b1;
          end else if (system_bus_rd_data != 32'd1) begin
            en_r    <= 1'b0;
            state_r <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          k_idx_r <= k_next_s;
          m_idx_r <= m_next_s;
          n_idx_r <= n_next_s;
          if (job_end_s) begin
            en_r         <= 1'b1;
            rdwr_r       <= 1'b0;
            addr_r       <= REG_DIM;
            poll_armed_r <= 1'b0;
            state_r      <= S_DONE_POLL;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_DONE_POLL: begin
          if (!poll_armed_r) begin
            poll_armed_r <= 1'b1;
          end else if (system_bus_rd_data == 32'd1) begin
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Hardware replacement for the software tiling loop that programs the gemm accelerator over its system bus. The block takes a whole-matrix job: base addresses of A (MxK), B (KxN) and C (MxN), plus M, K and N. It walks the N/M/K tile loops, writes each tile's configuration registers into gemm and throttles on gemm's "full" status. When the job is finished it waits for gemm's "done" status. It sits upstream of gemm, as the only master on gemm's system_bus port.

Parameters:
SYS_ROWS, 16, K-tile depth (SUPER_SYS_ROWS)
SYS_COLS, 16, N-tile width (SUPER_SYS_COLS)
M_TILE, 16, M-tile height
GEMM_BASE, 32'h9000_0000, gemm register base address
DIM_W, 16, width of the M/K/N job inputs

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  job start pulse; ignored unless idle
a_base  in  32  A base address (row-major, row stride K)
b_base  in  32  B base address (row stride N)
c_base  in  32  C base address (row stride N)
dim_m  in  DIM_W  M
dim_k  in  DIM_W  K
dim_n  in  DIM_W  N
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
err  out  1  one-cycle pulse when start is given with any dimension equal to 0
tile_count  out  32  tiles issued in the current or last job
system_bus_en  out  1  bus request
system_bus_rdwr  out  1  1 = write, 0 = read
system_bus_addr  out  32  register address
system_bus_wr_data  out  32  write data
system_bus_rd_data  in  32  read data, valid the cycle after a read request

Behaviour:
- Reset (async, rst=0): all outputs 0, FSM in IDLE, tile_count 0. Reset mid-job abandons the job immediately; system_bus_en drops asynchronously.
- start is sampled only in IDLE. On start, all job inputs are latched.
  - If any dimension is 0: pulse err the next cycle, stay IDLE, no bus traffic.
  - Otherwise: tile_count <= 0, busy <= 1, go to CALC.
- Loop order: n outer (step SYS_COLS), m middle (step M_TILE), k inner (step SYS_ROWS). All loop indices start at 0.
- Tile sizes: nt = min(SYS_COLS, N-n), mt = min(M_TILE, M-m), kt = min(SYS_ROWS, K-k).
- Per-tile values (32-bit, modulo 2^32):
  - TA = a_base + m*K + k
  - TB = b_base + (k+kt-1)*N + n
  - TC = c_base + m*N + n
  - first = (k==0); last = (k+SYS_ROWS >= K)
- Multiplies may be replaced by incremental pointers; results must be identical.
- CALC (1 cycle) computes the tile values.
- Write sequence, one write per cycle, system_bus_en=1 and rdwr=1:
  - WR_AS: BASE+12 <= K
  - WR_BS: BASE+16 <= N
  - WR_A: BASE+0 <= TA
  - WR_B: BASE+4 <= TB
  - WR_C: BASE+8 <= TC
  - WR_CTRL: BASE+20 <= {first,last}
  - WR_DIM: BASE+24 <= mt | kt<<5 | nt<<10. tile_count increments in this cycle.
- POLL: read BASE+0 (en=1, rdwr=0) held continuously. Starting the cycle after the first read request, sample rd_data each cycle.
  - rd_data==1: stay in POLL (gemm full).
  - Otherwise: go to ADVANCE.
- ADVANCE (1 cycle, en=0):
  - If more k remains: k += SYS_ROWS.
  - Else k=0 and m += M_TILE; if m wraps past M, then m=0 and n += SYS_COLS.
  - If n >= N, go to DONE_POLL; else go to CALC.
- DONE_POLL: read BASE+24 held continuously; sample as in POLL.
  - rd_data==1: go to IDLE, busy <= 0, done pulses 1 cycle.
  - Otherwise: stay in DONE_POLL.
- system_bus_en is 0 in IDLE, CALC and ADVANCE.
- Bus outputs are registered. Nothing is driven in IDLE: addr and wr_data are held, en=0.
- No timeout: a permanently full or never-done gemm keeps the block in POLL or DONE_POLL. Only rst escapes.
- start asserted while busy is ignored, with no effect on the running job.
- Tiles per job = ceil(N/SYS_COLS) * ceil(M/M_TILE) * ceil(K/SYS_ROWS).

Test Plan:
- M=K=N=16, a_base=0, b_base=256, c_base=512; bus model returns full=0, done=1. Required response:
  - Exactly 7 writes: (+12,16), (+16,16), (+0,0), (+4,496), (+8,512), (+20,3), (+24,16912).
  - One poll, then the done poll; done pulses once; tile_count=1.
  - First write occurs 2 cycles after start is sampled.
- M=17, K=40, N=20, a_base=0, b_base=680, c_base=1480. Required response:
  - 12 DIM writes.
  - CTRL sequence per (n,m) group is 2, 0, 1.
  - Final tile: TB=1476, DIM=4353, TC=1480+16*20+16=1816.
  - tile_count=12.
- Bus model holds full=1 for 5 cycles after the 3rd DIM write. Required response: the sequencer stays in POLL with en=1/rdwr=0 on BASE+0 for those cycles, and the next write (BASE+12) appears exactly 2 cycles after full drops (ADVANCE, CALC).
- start with dim_k=0 -> err pulses 1 cycle, no bus activity, busy stays 0. A start pulse mid-job -> no change to the bus sequence or tile_count.
- rst asserted during WR_B of tile 2 -> all outputs 0 asynchronously. After release, a new start runs a full job correctly from tile 0.
- Done model: return 0 for 10 cycles after the final tile -> busy stays 1 and done pulses only after the done register reads 1.
